rld_app_req_bridge: RTL

- User-side front end for the RLDRAM-II controller (rld_mem_interface_top), sitting directly upstream of its application FIFOs.
- Accepts tagged read/write requests on a valid/ready stream and pushes the address and write-data FIFO words for each one.
- Collects the two-beat BL4 read returns into tagged, in-order responses.
- Limits in-flight reads with a credit counter, because the controller's read path has no backpressure.

---
 rtl/rld_app_pkg.sv | 28 ++
 rtl/rld_sync_fifo.sv | 57 +++++
 rtl/rld_app_req_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rld_app_pkg.sv
// Shared definitions for the RLDRAM-II application request bridge:
// FSM state encodings and the address-FIFO word layout {wr, rd, 1'b0, addr, ba}.
package rld_app_pkg;

  typedef logic [0:0] bridge_state_t;

  localparam bridge_state_t ST_IDLE = 1'b0;
  localparam bridge_state_t ST_WR2  = 1'b1;

  localparam int AF_FLAG_BITS = 3;

  function automatic int app_ad_width(input int dev_ad, input int dev_ba);
    return AF_FLAG_BITS + dev_ad + dev_ba;
  endfunction

  function automatic int af_addr_lsb(input int dev_ba);
    return dev_ba;
  endfunction

  function automatic int af_rd_bit(input int dev_ad, input int dev_ba);
    return dev_ad + dev_ba + 1;
  endfunction

  function automatic int af_wr_bit(input int dev_ad, input int dev_ba);
    return dev_ad + dev_ba + 2;
  endfunction

endpackage

// File: rtl/rld_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags; DEPTH must be a power of 2.
module rld_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == COUNT_FULL);
  assign empty   = (count_r == CW'(0));
  assign push_s  = wr_en && !full;
  assign pop_s   = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rld_app_req_bridge.sv
// User-side request/response bridge in front of the RLDRAM-II controller FIFOs.
// Optional statistics counters are built when RLD_BRIDGE_STATS_EN is defined.
module rld_app_req_bridge
  import rld_app_pkg::*;
#(
  parameter int RL_DQ_WIDTH     = 72,
  parameter int DEV_AD_WIDTH    = 20,
  parameter int DEV_BA_WIDTH    = 3,
  parameter int APP_AD_WIDTH    = app_ad_width(DEV_AD_WIDTH, DEV_BA_WIDTH),
  parameter int TAG_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       sysClk,
  input  logic                       sysRst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [DEV_BA_WIDTH-1:0]    req_ba,
  input  logic [DEV_AD_WIDTH-1:0]    req_addr,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  input  logic [4*RL_DQ_WIDTH-1:0]   req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TAG_WIDTH-1:0]       rsp_tag,
  output logic [4*RL_DQ_WIDTH-1:0]   rsp_data,
  output logic                       app_af_wr_en,
  output logic [APP_AD_WIDTH-1:0]    app_af_data,
  input  logic                       app_af_full,
  output logic                       app_wdf_wr_en,
  output logic [2*RL_DQ_WIDTH-1:0]   app_wdf_data,
  input  logic                       app_wdf_full,
  input  logic                       app_rd_valid,
  input  logic [2*RL_DQ_WIDTH-1:0]   app_rd_data,
  output logic                       err_unexp_rd
`ifdef RLD_BRIDGE_STATS_EN
  ,
  output logic [31:0]                stat_wr_cnt,
  output logic [31:0]                stat_rd_cnt,
  output logic [31:0]                stat_stall_cnt
`endif
);

  localparam int DW  = 2 * RL_DQ_WIDTH;
  localparam int BW  = 4 * RL_DQ_WIDTH;
  localparam int RW  = TAG_WIDTH + BW;
  localparam int CRW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CRW-1:0] CRED_MAX = CRW'(MAX_OUTSTANDING);

  bridge_state_t           state_r;
  logic [CRW-1:0]          credits_r;
  logic                    af_wr_en_r;
  logic [APP_AD_WIDTH-1:0] af_data_r;
  logic                    wdf_wr_en_r;
  logic [DW-1:0]           wdf_data_r;
  logic [DW-1:0]           wdata_hi_r;
  logic [DW-1:0]           half_r;
  logic                    phase_r;
  logic                    err_r;

  logic                    req_ready_s;
  logic                    accept_s;
  logic                    wr_acc_s;
  logic                    rd_acc_s;
  logic                    rsp_pop_s;
  logic [APP_AD_WIDTH-1:0] af_word_s;
  logic                    beat_first_s;
  logic                    beat_second_s;
  logic                    unexp_s;
  logic                    tag_full_s;
  logic                    tag_empty_s;
  logic [TAG_WIDTH-1:0]    tag_head_s;
  logic                    rsp_full_s;
  logic                    rsp_empty_s;
  logic [RW-1:0]           rsp_head_s;

  // Accept decision; tag/response FIFO fullness is implied by the credit limit.
  always_comb begin
    req_ready_s = 1'b0;
    if (sysRst_n && (state_r == ST_IDLE) && !app_af_full) begin
      if (req_wr) begin
        req_ready_s = !app_wdf_full;
      end else begin
        req_ready_s = (credits_r < CRED_MAX) && !tag_full_s && !rsp_full_s;
      end
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign accept_s  = req_valid && req_ready_s;
  assign wr_acc_s  = accept_s && req_wr;
  assign rd_acc_s  = accept_s && !req_wr;
  assign rsp_pop_s = !rsp_empty_s && rsp_ready;

  // Address-FIFO word assembly.
  always_comb begin
    af_word_s = '0;
    af_word_s[af_wr_bit(DEV_AD_WIDTH, DEV_BA_WIDTH)] = req_wr;
    af_word_s[af_rd_bit(DEV_AD_WIDTH, DEV_BA_WIDTH)] = ~req_wr;
    af_word_s[af_addr_lsb(DEV_BA_WIDTH) +: DEV_AD_WIDTH] = req_addr;
    af_word_s[DEV_BA_WIDTH-1:0] = req_ba;
  end

  // Request FSM and registered controller-side pushes.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_r     <= ST_IDLE;
      af_wr_en_r  <= 1'b0;
      af_data_r   <= '0;
      wdf_wr_en_r <= 1'b0;
      wdf_data_r  <= '0;
      wdata_hi_r  <= '0;
    end else begin
      af_wr_en_r  <= accept_s;
      wdf_wr_en_r <= 1'b0;
      if (accept_s) af_data_r <= af_word_s;
      case (state_r)
        ST_IDLE: begin
          if (wr_acc_s) begin
            wdf_wr_en_r <= 1'b1;
            wdf_data_r  <= req_wdata[DW-1:0];
            wdata_hi_r  <= req_wdata[BW-1:DW];
            state_r     <= ST_WR2;
          end
        end
        ST_WR2: begin
          if (!app_wdf_full) begin
            wdf_wr_en_r <= 1'b1;
            wdf_data_r  <= wdata_hi_r;
            state_r     <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Read credits: one per accepted read, returned when its response is popped.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      credits_r <= '0;
    end else begin
      case ({rd_acc_s, rsp_pop_s})
        2'b10:   credits_r <= credits_r + CRW'(1);
        2'b01:   credits_r <= credits_r - CRW'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  assign beat_first_s  = app_rd_valid && !phase_r && !tag_empty_s;
  assign beat_second_s = app_rd_valid && phase_r;
  assign unexp_s       = app_rd_valid && !phase_r && tag_empty_s;

  // Two-beat read collection and sticky unexpected-data flag.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      half_r  <= '0;
      phase_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (beat_first_s) begin
        half_r  <= app_rd_data;
        phase_r <= 1'b1;
      end
      if (beat_second_s) phase_r <= 1'b0;
      if (unexp_s)       err_r   <= 1'b1;
    end
  end

  rld_sync_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (sysClk),
    .rst_n   (sysRst_n),
    .wr_en   (rd_acc_s),
    .wr_data (req_tag),
    .rd_en   (beat_second_s),
    .rd_data (tag_head_s),
    .full    (tag_full_s),
    .empty   (tag_empty_s)
  );

  rld_sync_fifo #(.WIDTH(RW), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk     (sysClk),
    .rst_n   (sysRst_n),
    .wr_en   (beat_second_s),
    .wr_data ({tag_head_s, app_rd_data, half_r}),
    .rd_en   (rsp_pop_s),
    .rd_data (rsp_head_s),
    .full    (rsp_full_s),
    .empty   (rsp_empty_s)
  );

  assign req_ready     = req_ready_s;
  assign app_af_wr_en  = af_wr_en_r;
  assign app_af_data   = af_data_r;
  assign app_wdf_wr_en = wdf_wr_en_r;
  assign app_wdf_data  = wdf_data_r;
  assign err_unexp_rd  = err_r;
  assign rsp_valid     = !rsp_empty_s;
  assign rsp_tag       = rsp_head_s[RW-1:BW];
  assign rsp_data      = rsp_head_s[BW-1:0];

`ifdef RLD_BRIDGE_STATS_EN
  logic [31:0] stat_wr_r;
  logic [31:0] stat_rd_r;
  logic [31:0] stat_stall_r;

  // Wrapping activity counters.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      stat_wr_r    <= 32'd0;
      stat_rd_r    <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if (wr_acc_s) stat_wr_r <= stat_wr_r + 32'd1;
      if (rd_acc_s) stat_rd_r <= stat_rd_r + 32'd1;
      if (req_valid && !req_ready_s) stat_stall_r <= stat_stall_r + 32'd1;
    end
  end

  assign stat_wr_cnt    = stat_wr_r;
  assign stat_rd_cnt    = stat_rd_r;
  assign stat_stall_cnt = stat_stall_r;
`endif

endmodule
